// File: rtl/sram_initiator_pkg.sv
// sram_initiator_pkg
//   Shared types and constants for the SRAM port initiator.
//   - state_e      : controller state (INIT zero-fill, RUN normal traffic)
//   - DEF_*        : default word width / address width of the target macro
//   - IDLE_*       : macro command levels driven when no command is issued
package sram_initiator_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 7;

    // Idle command: chip deselected, write disabled; addr0/din0 idle at zero.
    localparam logic IDLE_CSB = 1'b1;
    localparam logic IDLE_WEB = 1'b1;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
//   Two-entry synchronous response FIFO. The head entry is held in its own
//   register so rdata_o comes straight from a flop and stays stable while
//   the consumer stalls.
// Ports:
//   clk, rst_n    clock, async active-low reset (clears contents and count)
//   push_i        write push_data_i into the queue
//   push_data_i   data to enqueue
//   pop_i         consumer takes the head entry (ignored when empty)
//   rdata_o       head entry
//   valid_o       queue not empty
//   full_o        two entries held
//   empty_o       no entries held
//   count_o       occupancy 0..2
module sram_rsp_fifo
    import sram_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full queue is only legal when the head leaves the same cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (do_push) begin
                    head_d  = push_data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (do_push && do_pop) begin
                    head_d = push_data_i;
                end else if (do_push) begin
                    tail_d  = push_data_i;
                    count_d = 2'd2;
                end else if (do_pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (do_pop) begin
                    head_d = tail_q;
                    if (do_push) begin
                        tail_d = push_data_i;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rdata_o = head_q;
    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/sram_port_initiator.sv
// sram_port_initiator
//   Drives one RW port of an OpenRAM macro from a valid/ready request stream.
//   Reads return through a 2-entry response queue; writes are posted.
//   With INIT_CLEAR=1 the whole array is zero-filled after reset before any
//   request is accepted.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   INIT  | zero-fill: one write per cycle, address 0..RAM_DEPTH-1
//   RUN   | one macro command per accepted request
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake
//   req_we, req_addr, req_wdata request fields (1 = write)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata                   read data, in request order
//   init_done                   zero-fill finished (or skipped)
//   csb0, web0, addr0, din0     registered macro command (active-low csb/web)
//   dout0                       macro read data, sampled one cycle after a read
module sram_port_initiator
    import sram_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic [1:0]            outstanding;
    logic                  rsp_pop;
    logic                  accept;

    // Credits cover the read on the macro plus everything already queued, so
    // an accepted read always has a queue slot by the time its data returns.
    assign outstanding = fifo_count + {1'b0, rd_inflight_q};
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign req_ready   = (state_q == RUN) && init_done_q
                         && !(fifo_full && !rsp_ready)
                         && ((outstanding < 2'd2) || rsp_pop);
    assign accept      = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_inflight_d = 1'b0;
        csb_d         = IDLE_CSB;
        web_d         = IDLE_WEB;
        addr_d        = '0;
        din_d         = '0;
        case (state_q)
            INIT: begin
                csb_d  = 1'b0;
                web_d  = 1'b0;
                addr_d = cnt_q;
                cnt_d  = cnt_q + ADDR_WIDTH'(1);
                if (&cnt_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    csb_d         = 1'b0;
                    web_d         = ~req_we;
                    addr_d        = req_addr;
                    din_d         = req_we ? req_wdata : '0;
                    rd_inflight_d = ~req_we;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // init_done trails the INIT->RUN transition by one cycle, which lines the
    // first accept slot up RAM_DEPTH cycles after the first fill command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT_CLEAR ? INIT : RUN;
            cnt_q         <= '0;
            init_done_q   <= 1'b0;
            rd_inflight_q <= 1'b0;
            csb_q         <= IDLE_CSB;
            web_q         <= IDLE_WEB;
            addr_q        <= '0;
            din_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_done_q   <= (state_q == RUN);
            rd_inflight_q <= rd_inflight_d;
            csb_q         <= csb_d;
            web_q         <= web_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rd_inflight_q),
        .push_data_i (dout0),
        .pop_i       (rsp_ready),
        .rdata_o     (rsp_rdata),
        .valid_o     (rsp_valid),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign init_done = init_done_q;
    assign csb0      = csb_q;
    assign web0      = web_q;
    assign addr0     = addr_q;
    assign din0      = din_q;

endmodule

// File: tb/tb_sram_port_initiator.sv
// tb_sram_port_initiator
//   Directed bench: one INIT_CLEAR=1 instance backed by a behavioural SRAM,
//   one INIT_CLEAR=0 instance checked for reset-release behaviour.
module tb_sram_port_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        init_done;
    logic        csb0, web0;
    logic [6:0]  addr0;
    logic [31:0] din0, dout0;

    logic        rst_nc;
    logic        nc_req_ready, nc_rsp_valid, nc_init_done, nc_csb0, nc_web0;
    logic [31:0] nc_rsp_rdata, nc_din0;
    logic [6:0]  nc_addr0;

    int checks = 0;
    int passes = 0;

    logic [6:0]  seq_addr [8];
    logic [31:0] seq_exp  [8];

    always #5 clk = ~clk;

    // Behavioural macro: writes land on the edge, read data follows addr0.
    logic [31:0] mem [128];
    always @(posedge clk) if (!csb0 && !web0) mem[addr0] <= din0;
    assign dout0 = mem[addr0];

    sram_port_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .INIT_CLEAR(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    sram_port_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .INIT_CLEAR(1'b0)) u_dut_nc (
        .clk(clk), .rst_n(rst_nc),
        .req_valid(1'b0), .req_ready(nc_req_ready), .req_we(1'b0),
        .req_addr(7'd0), .req_wdata(32'd0),
        .rsp_valid(nc_rsp_valid), .rsp_ready(1'b0), .rsp_rdata(nc_rsp_rdata),
        .init_done(nc_init_done),
        .csb0(nc_csb0), .web0(nc_web0), .addr0(nc_addr0), .din0(nc_din0), .dout0(32'd0)
    );

    // Presents a request from the next falling edge until it is accepted.
    // Returns #1 after the accepting rising edge.
    task automatic send(input logic we, input logic [6:0] a, input logic [31:0] d,
                        output logic acc);
        acc = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int i = 0; i < 16; i++) begin
            #1;
            acc = req_ready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid, init_done, csb0, web0} !== 5'b00011 ||
            rsp_rdata !== 32'd0 || addr0 !== 7'd0 || din0 !== 32'd0) begin
            $display("FAIL reset_values: rdy=%b vld=%b done=%b csb=%b web=%b rdata=%h addr=%h din=%h required 0,0,0,1,1,0,0,0",
                     req_ready, rsp_valid, init_done, csb0, web0, rsp_rdata, addr0, din0);
        end else passes++;
    endtask

    task automatic test_no_clear();
        checks++;
        if (nc_req_ready !== 1'b0 || nc_init_done !== 1'b0 || nc_csb0 !== 1'b1)
            $display("FAIL nc_reset: rdy=%b done=%b csb=%b required 0 0 1", nc_req_ready, nc_init_done, nc_csb0);
        else passes++;
        @(negedge clk);
        rst_nc = 1'b1;
        #1;
        checks++;
        if (nc_req_ready !== 1'b0)
            $display("FAIL nc_ready_before_edge: got %b required 0", nc_req_ready);
        else passes++;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (nc_csb0 !== 1'b1 || nc_web0 !== 1'b1 || nc_init_done !== 1'b1 || nc_req_ready !== 1'b1)
                $display("FAIL nc_run_cycle%0d: csb=%b web=%b done=%b rdy=%b required 1 1 1 1",
                         k, nc_csb0, nc_web0, nc_init_done, nc_req_ready);
            else passes++;
        end
    endtask

    task automatic test_init();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 129; k++) begin
            @(posedge clk); #1;
            if (k <= 128) begin
                checks++;
                if (csb0 !== 1'b0 || web0 !== 1'b0 || addr0 !== 7'(k - 1) || din0 !== 32'd0)
                    $display("FAIL init_cmd%0d: csb=%b web=%b addr=%0d din=%h required 0 0 %0d 0",
                             k, csb0, web0, addr0, din0, k - 1);
                else passes++;
            end
            checks++;
            if (init_done !== (k == 129))
                $display("FAIL init_done_cycle%0d: got %b required %b", k, init_done, (k == 129));
            else passes++;
        end
        checks++;
        if (req_ready !== 1'b1 || csb0 !== 1'b1)
            $display("FAIL init_exit: rdy=%b csb=%b required 1 1", req_ready, csb0);
        else passes++;
    endtask

    task automatic test_read_all();
        logic acc;
        rsp_ready = 1'b1;
        for (int a = 0; a < 128; a++) begin
            send(1'b0, 7'(a), 32'd0, acc);
            @(posedge clk); #1;
            checks++;
            if (acc !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'd0)
                $display("FAIL read_zero_addr%0d: acc=%b vld=%b rdata=%h required 1 1 00000000",
                         a, acc, rsp_valid, rsp_rdata);
            else passes++;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_write_read();
        logic acc_w, acc_r;
        rsp_ready = 1'b0;
        send(1'b1, 7'd5, 32'hDEADBEEF, acc_w);
        send(1'b0, 7'd5, 32'd0, acc_r);
        checks++;
        if (acc_w !== 1'b1 || acc_r !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL wr_rd_accept: accw=%b accr=%b vld=%b required 1 1 0", acc_w, acc_r, rsp_valid);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL wr_rd_data: vld=%b rdata=%h required 1 deadbeef", rsp_valid, rsp_rdata);
        else passes++;
        // Preload for the backpressure test while the response sits queued.
        send(1'b1, 7'd1, 32'h11, acc_w);
        send(1'b1, 7'd2, 32'h22, acc_r);
        checks++;
        if (acc_w !== 1'b1 || acc_r !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL preload_accept: acc=%b%b rdata=%h required 11 deadbeef", acc_w, acc_r, rsp_rdata);
        else passes++;
        send(1'b1, 7'd3, 32'h33, acc_w);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (acc_w !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL wr_rd_drain: acc=%b vld=%b required 1 0", acc_w, rsp_valid);
        else passes++;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd1; #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL bp_rd1_ready: got %b required 1", req_ready); else passes++;
        @(negedge clk);
        req_addr = 7'd2; #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL bp_rd2_ready: got %b required 1", req_ready); else passes++;
        @(negedge clk);
        req_addr = 7'd3; #1;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL bp_rd3_stall: got %b required 0", req_ready); else passes++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h11)
                $display("FAIL bp_hold%0d: rdy=%b vld=%b rdata=%h required 0 1 00000011",
                         k, req_ready, rsp_valid, rsp_rdata);
            else passes++;
        end
        @(negedge clk);
        rsp_ready = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b required 1", req_ready); else passes++;
        @(negedge clk);
        req_valid = 1'b0; #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22)
            $display("FAIL bp_drain2: vld=%b rdata=%h required 1 00000022", rsp_valid, rsp_rdata);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h33)
            $display("FAIL bp_drain3: vld=%b rdata=%h required 1 00000033", rsp_valid, rsp_rdata);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL bp_empty: vld=%b required 0", rsp_valid); else passes++;
    endtask

    task automatic test_stream();
        seq_addr = '{7'd1, 7'd2, 7'd3, 7'd5, 7'd5, 7'd3, 7'd2, 7'd1};
        seq_exp  = '{32'h11, 32'h22, 32'h33, 32'hDEADBEEF, 32'hDEADBEEF, 32'h33, 32'h22, 32'h11};
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = seq_addr[i];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (i < 8) begin
                checks++;
                if (req_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b required 1", i, req_ready);
                else passes++;
            end
            if (i == 1) begin
                checks++;
                if (rsp_valid !== 1'b0) $display("FAIL stream_latency: vld=%b required 0", rsp_valid);
                else passes++;
            end
            if (i >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== seq_exp[i-2])
                    $display("FAIL stream_rsp%0d: vld=%b rdata=%h required 1 %h",
                             i - 2, rsp_valid, rsp_rdata, seq_exp[i-2]);
                else passes++;
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL stream_empty: vld=%b required 0", rsp_valid); else passes++;
    endtask

    task automatic test_mid_reset();
        logic acc1, acc2;
        int   cyc;
        rsp_ready = 1'b0;
        send(1'b0, 7'd1, 32'd0, acc1);
        send(1'b0, 7'd2, 32'd0, acc2);
        @(posedge clk); #1;
        checks++;
        if (acc1 !== 1'b1 || acc2 !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h11 || req_ready !== 1'b0)
            $display("FAIL mr_queued: acc=%b%b vld=%b rdata=%h rdy=%b required 11 1 00000011 0",
                     acc1, acc2, rsp_valid, rsp_rdata, req_ready);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || csb0 !== 1'b1 || init_done !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL mr_async_flush: vld=%b rdata=%h csb=%b done=%b rdy=%b required 0 0 1 0 0",
                     rsp_valid, rsp_rdata, csb0, init_done, req_ready);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        // Interrupt the restarted fill while a command is on the macro port.
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (csb0 !== 1'b0 || addr0 !== 7'd9)
            $display("FAIL mr_init_restart: csb=%b addr=%0d required 0 9", csb0, addr0);
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (csb0 !== 1'b1 || web0 !== 1'b1 || addr0 !== 7'd0)
            $display("FAIL mr_cmd_idle: csb=%b web=%b addr=%0d required 1 1 0", csb0, web0, addr0);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (init_done) begin cyc = k; break; end
        end
        checks++;
        if (cyc != 129) $display("FAIL mr_reinit_done: edges=%0d required 129", cyc); else passes++;
        rsp_ready = 1'b1;
        send(1'b0, 7'd5, 32'd0, acc1);
        @(posedge clk); #1;
        checks++;
        if (acc1 !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'd0)
            $display("FAIL mr_addr5_cleared: acc=%b vld=%b rdata=%h required 1 1 00000000", acc1, rsp_valid, rsp_rdata);
        else passes++;
        send(1'b0, 7'd1, 32'd0, acc2);
        @(posedge clk); #1;
        checks++;
        if (acc2 !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'd0)
            $display("FAIL mr_addr1_cleared: acc=%b vld=%b rdata=%h required 1 1 00000000", acc2, rsp_valid, rsp_rdata);
        else passes++;
    endtask

    initial begin
        rst_n = 1'b0; rst_nc = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_no_clear();
        test_init();
        test_read_all();
        test_write_read();
        test_backpressure();
        test_stream();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sram_port_initiator.md
# sram_port_initiator

Initiator for one RW port of the team's dual-port OpenRAM macro (e.g. sky130_sram_2rw_32x128_32). Converts a valid/ready request stream (read or write) into the macro's active-low csb/web command protocol. Buffers read data in a 2-entry response queue with its own valid/ready handshake. After reset, optionally zero-fills the whole array before accepting traffic; sits between a core/cache datapath and one SRAM port.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; matches macro.
- ADDR_WIDTH, 7, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- INIT_CLEAR, 1, 1 = zero-fill all words after reset; 0 = skip.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a clk edge where valid&ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data, ignored on reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_rdata on valid&ready.
- rsp_rdata  out  DATA_WIDTH  read data, in request order.
- init_done  out  1  high once zero-fill is complete (or immediately if INIT_CLEAR=0).
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

## Operation
- Every macro-side output is registered.
  - Idle command: csb0=1, web0=1, addr0=0, din0=0.
- States:
  - INIT: entered on reset when INIT_CLEAR=1. Issues one write per cycle, address counter 0..RAM_DEPTH-1, data 0. req_ready=0.
    - After the write to RAM_DEPTH-1 has been issued, go to RUN and set init_done=1.
  - RUN: entered directly from reset when INIT_CLEAR=0. Command cycle for each accepted request.
- Write accepted at edge E0: during cycle E0..E1, csb0=0, web0=0, addr0=req_addr, din0=req_wdata. Writes are posted and produce no response.
- Read accepted at edge E0: during cycle E0..E1, csb0=0, web0=1, addr0=req_addr. At E1, dout0 is pushed into the response queue.
- Credits: outstanding = in-flight reads (0 or 1) + queue occupancy (0..2).
  - req_ready = (state==RUN) && (outstanding < 2 || (rsp_valid && rsp_ready)).
  - Writes follow the same req_ready rule; no separate write path.
- Ordering: strict in-order. A read issued the cycle after a write to the same address returns the new data.
- A queue push and pop in the same cycle are both performed; occupancy is unchanged.
- Reset asserted mid-operation: queue flushed, in-flight read dropped, commands go idle immediately, INIT restarts.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, csb0=1, web0=1, addr0=0, din0=0.
- INIT_CLEAR=1: the first INIT command is driven in the first cycle after rst_n deasserts.
  - init_done and req_ready go high RAM_DEPTH cycles after that (128 for the default depth).
- INIT_CLEAR=0: init_done=1 and req_ready=1 from the first edge after reset release.
- Read latency: accept edge E0 -> rsp_valid=1 after E1 (1 cycle) when the queue is empty.
- Throughput: one request per cycle while rsp_ready=1; stalls only on credits.
- Queue full (2 entries, rsp_ready=0): req_ready=0 even for writes, until a pop occurs.
- rsp_rdata holds stable while rsp_valid=1 and rsp_ready=0.

## Structure
- Package sram_initiator_pkg holds:
  - state enum {INIT, RUN};
  - default width/depth constants;
  - the idle command values.
- Sub-module sram_rsp_fifo: 2-entry synchronous FIFO with registered outputs and occupancy count.
  - Clears on rst_n.
  - Exposes full, empty and count to the top-level credit logic.

## Test plan
- Reset with INIT_CLEAR=1, then read all 128 addresses -> init_done rises 128 cycles after release; every rsp_rdata = 0x00000000.
- Write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle -> rsp_rdata=0xDEADBEEF, rsp_valid rises 1 cycle after the read is accepted.
- Back-to-back reads of addrs 1,2,3 (preloaded 0x11,0x22,0x33) with rsp_ready=0 -> third request stalls (req_ready=0). Raising rsp_ready drains 0x11,0x22,0x33 in order.
- Simultaneous push and pop with rsp_ready=1 and continuous reads -> one response per cycle, req_ready stays 1, occupancy never exceeds 1.
- rst_n pulsed low with 2 responses queued -> rsp_valid=0, csb0=1 asynchronously; INIT restarts, and reading the previously written addr 5 returns 0.
- INIT_CLEAR=0 -> no macro writes after reset; req_ready=1 on the first cycle after release.
